// File: rtl/rv_pkg.sv
// Shared fetch-path types and defaults.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam int INST_W = 32;

  // One fetch buffer slot: the PC tag is written at request time,
  // the instruction and filled flag at response time.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// PC-tagged in-order fetch FIFO: allocate on request, fill on response, pop to decode.
module fetch_buffer
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill,
  input  logic [INST_W-1:0]        fill_inst,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   unfilled
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  ent [DEPTH];
  logic [AW-1:0] alloc_ptr, fill_ptr, head_ptr;

  assign head = ent[head_ptr];

  // Pointer, occupancy and entry update; flush drops every entry but keeps stale payloads.
  // Alloc, fill and pop always address different slots, so they can coexist in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      unfilled  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      unfilled  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        ent[alloc_ptr].pc     <= alloc_pc;
        ent[alloc_ptr].filled <= 1'b0;
        alloc_ptr             <= alloc_ptr + AW'(1);
      end
      if (fill) begin
        ent[fill_ptr].inst   <= fill_inst;
        ent[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + AW'(1);
      end
      if (pop) begin
        ent[head_ptr].filled <= 1'b0;
        head_ptr             <= head_ptr + AW'(1);
      end
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, request gating,
// squashed-response drop counter and the PC-tagged fetch buffer.
module if_fetch_unit #(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [31:0]     io_imem_resp_data,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc,
  output logic            io_id_valid,
  input  logic            io_id_ready,
  output logic [XLEN-1:0] io_id_pc,
  output logic [31:0]     io_id_inst
);
  import rv_pkg::fetch_entry_t;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt, count, unfilled;
  logic [CW:0]     occupancy;
  logic            req_fire, fill, pop;
  fetch_entry_t    head;

  // Target is forced word aligned, so the low two bits are never used.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^io_redirect_pc[1:0];

  // Squashed-but-outstanding requests still hold a slot until their response returns.
  assign occupancy         = {1'b0, count} + {1'b0, drop_cnt};
  assign io_imem_req_valid = !reset && !io_redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign io_imem_req_addr  = pc;
  assign req_fire          = io_imem_req_valid && io_imem_req_ready;

  assign fill        = io_imem_resp_valid && (drop_cnt == '0) && !io_redirect_valid;
  assign io_id_valid = !reset && head.filled && !io_redirect_valid;
  assign pop         = io_id_valid && io_id_ready;
  assign io_id_pc    = head.pc;
  assign io_id_inst  = head.inst;

  // Fetch PC: redirect wins over sequential advance; wraps naturally at 2^XLEN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  pc <= RESET_PC;
    else if (io_redirect_valid) pc <= {io_redirect_pc[XLEN-1:2], 2'b00};
    else if (req_fire)          pc <= pc + XLEN'(4);
  end

  // Drop counter: on redirect, every still-unanswered request becomes stale;
  // a response arriving that same cycle already retires one of them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (io_redirect_valid)
      drop_cnt <= drop_cnt + unfilled - CW'(io_imem_resp_valid);
    else if (io_imem_resp_valid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - CW'(1);
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_redirect_valid),
    .alloc     (req_fire),
    .alloc_pc  (pc),
    .fill      (fill),
    .fill_inst (io_imem_resp_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .unfilled  (unfilled)
  );

  // A response must always belong to some outstanding (live or squashed) request.
  a_resp_has_req: assert property (@(posedge clock) disable iff (reset)
    io_imem_resp_valid |-> (drop_cnt != '0 || unfilled != '0));

  // Tracked slots never exceed the buffer size.
  a_occupancy: assert property (@(posedge clock) disable iff (reset)
    occupancy <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: randomized memory latency/ready and
// decode backpressure, redirects, and async reset, against a queue-level model.
module tb_if_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock, reset;
  logic        io_imem_req_valid, io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_id_valid, io_id_ready;
  logic [31:0] io_id_pc, io_id_inst;

  if_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_id_valid        (io_id_valid),
    .io_id_ready        (io_id_ready),
    .io_id_pc           (io_id_pc),
    .io_id_inst         (io_id_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model: in-order, per-request latency ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int mcyc = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;

  initial begin
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    forever begin
      @(posedge clock); #1;
      mcyc++;
      if (reset) begin
        mq.delete();
        io_imem_resp_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= mcyc) begin
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data  = inst_of(mq[0].addr);
        mq.delete(0);
      end else begin
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data  = $urandom;
      end
      io_imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clock);
      if (reset) mq.delete();
      else if (io_imem_req_valid && io_imem_req_ready)
        mq.push_back('{addr: io_imem_req_addr, due: mcyc + int'($urandom_range(lat_max, lat_min))});
    end
  end

  // ---------------- reference model + monitor ----------------
  // sbq holds every request accepted since the last redirect/reset, oldest first,
  // with whether its instruction has come back. stale counts squashed requests
  // whose responses are still on their way.
  typedef struct { logic [31:0] pc; bit filled; } sb_t;
  sb_t         sbq[$];
  logic [31:0] mpc = RST_PC;
  int          inflight = 0, stale = 0;

  always @(negedge clock) begin
    bit exp_rv, exp_iv, placed;
    if (reset) begin
      chk("rst_req_valid", {31'b0, io_imem_req_valid}, 32'd0);
      chk("rst_id_valid",  {31'b0, io_id_valid}, 32'd0);
      chk("rst_id_pc",     io_id_pc, 32'd0);
      chk("rst_id_inst",   io_id_inst, 32'd0);
      sbq.delete();
      mpc = RST_PC; inflight = 0; stale = 0;
    end else begin
      exp_rv = (sbq.size() + stale < DEPTH) && !io_redirect_valid;
      exp_iv = (sbq.size() > 0) && sbq[0].filled && !io_redirect_valid;
      chk("req_valid", {31'b0, io_imem_req_valid}, {31'b0, exp_rv});
      chk("id_valid",  {31'b0, io_id_valid}, {31'b0, exp_iv});
      if (exp_rv) chk("req_addr", io_imem_req_addr, mpc);
      if (exp_iv) begin
        chk("id_pc",   io_id_pc, sbq[0].pc);
        chk("id_inst", io_id_inst, inst_of(sbq[0].pc));
      end
      if (io_redirect_valid) begin
        if (io_imem_resp_valid && inflight > 0) inflight--;
        stale = inflight;
        sbq.delete();
        mpc = {io_redirect_pc[31:2], 2'b00};
      end else begin
        if (io_imem_resp_valid) begin
          if (inflight > 0) inflight--;
          if (stale > 0) stale--;
          else begin
            placed = 1'b0;
            foreach (sbq[i]) if (!placed && !sbq[i].filled) begin
              sbq[i].filled = 1'b1;
              placed = 1'b1;
            end
            if (!placed) begin
              errors++;
              $display("FAIL resp_orphan: response with no live request at %0t", $time);
            end
          end
        end
        if (exp_iv && io_id_ready) sbq.delete(0);
        if (exp_rv && io_imem_req_ready) begin
          sbq.push_back('{pc: mpc, filled: 1'b0});
          inflight++;
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int idr_pct = 100, redir_pct = 0;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      io_id_ready       = (int'($urandom_range(99)) < idr_pct);
      io_redirect_valid = (int'($urandom_range(99)) < redir_pct);
      case ($urandom_range(2))
        0:       io_redirect_pc = RST_PC + {22'b0, 10'($urandom)};
        1:       io_redirect_pc = 32'hFFFF_FFF0 + {28'b0, 4'($urandom)};
        default: io_redirect_pc = $urandom;
      endcase
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    @(posedge clock); #1;
    io_redirect_valid = 1'b1;
    io_redirect_pc    = target;
    @(posedge clock); #1;
    io_redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    io_redirect_valid = 1'b0;
    #1;
    chk("async_rst_req_valid", {31'b0, io_imem_req_valid}, 32'd0);
    chk("async_rst_id_valid",  {31'b0, io_id_valid}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = '0;
    io_id_ready       = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // streaming, latency 1, decode always ready
    cycles(20);

    // decode stalled for 10 cycles, then drains
    do_reset();
    idr_pct = 0;  cycles(10);
    idr_pct = 100; cycles(15);

    // latency 3, two requests in flight, unaligned redirect target
    do_reset();
    lat_min = 3; lat_max = 3;
    cycles(2);
    redirect_to(32'h8000_0103);
    cycles(20);

    // redirect in the same cycle as a response
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock); #2;
      if (io_imem_resp_valid) begin
        found = 1'b1;
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'h8000_0200;
        @(posedge clock); #1;
        io_redirect_valid = 1'b0;
      end
    end
    chk("resp_seen_for_redirect", {31'b0, found}, 32'd1);
    cycles(15);

    // wrap across the top of the address space
    lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFF_FFF8);
    cycles(12);

    // reset with entries buffered, then restart
    idr_pct = 0; cycles(6);
    do_reset();
    idr_pct = 100; cycles(10);

    // random traffic
    lat_min = 1; lat_max = 4; rdy_pct = 75; idr_pct = 70; redir_pct = 4;
    cycles(1500);
    redir_pct = 0; idr_pct = 100; rdy_pct = 100;
    cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
